// File: rtl/level_shifter_mc.sv
// Multi-channel level shifter: supply-gated power-good FSM, per-channel hysteresis
// comparator plus consecutive-sample filter, and real-valued output drive.
module level_shifter_mc #(
    parameter int  N_CH     = 4,
    parameter real VTH_HI   = 1.9,
    parameter real VTH_LO   = 1.7,
    parameter int  FILT_LEN = 3,
    parameter real PG_MIN   = 3.0,
    parameter int  PG_DLY   = 8
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            EN,
    input  real             VIN [N_CH],
    input  real             VCC_LOW,
    input  real             VCC_HIGH,
    output real             VOUT [N_CH],
    output logic [N_CH-1:0] DOUT,
    output logic [N_CH-1:0] CHG,
    output logic            PGOOD
);

    localparam int PCW = $clog2(PG_DLY + 1);
    localparam int FCW = $clog2(FILT_LEN + 1);
    localparam logic [PCW-1:0] PG_LAST   = PCW'(PG_DLY - 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_WAIT,
        ST_ON
    } state_t;

    state_t          state_q, state_d;
    logic [PCW-1:0]  pg_cnt_q, pg_cnt_d;
    logic            supply_ok;
    logic            run;

    logic [N_CH-1:0] raw_q, raw_d;
    logic [N_CH-1:0] dout_q, dout_d;
    logic [N_CH-1:0] chg_q, chg_d;
    logic [FCW-1:0]  cnt_q [N_CH];
    logic [FCW-1:0]  cnt_d [N_CH];

    // Supply sequencing: a failing supply or a dropped enable wins over everything.
    always_comb begin
        state_d   = state_q;
        pg_cnt_d  = pg_cnt_q;
        supply_ok = EN && (VCC_HIGH >= PG_MIN);
        case (state_q)
            ST_OFF: begin
                if (supply_ok) begin
                    state_d  = ST_WAIT;
                    pg_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (!supply_ok) begin
                    state_d  = ST_OFF;
                    pg_cnt_d = '0;
                end else if (pg_cnt_q == PG_LAST) begin
                    state_d  = ST_ON;
                    pg_cnt_d = '0;
                end else begin
                    pg_cnt_d = pg_cnt_q + PCW'(1);
                end
            end
            ST_ON: begin
                if (!supply_ok) begin
                    state_d  = ST_OFF;
                    pg_cnt_d = '0;
                end
            end
            default: begin
                state_d  = ST_OFF;
                pg_cnt_d = '0;
            end
        endcase
    end

    // Channels run only while ON persists; the exit edge already clears them.
    assign run = (state_q == ST_ON) && (state_d == ST_ON);

    always_comb begin
        raw_d  = '0;
        dout_d = '0;
        chg_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (run) begin
                if (VIN[i] > VTH_HI) begin
                    raw_d[i] = 1'b1;
                end else if (VIN[i] < VTH_LO) begin
                    raw_d[i] = 1'b0;
                end else begin
                    raw_d[i] = raw_q[i];
                end
                dout_d[i] = dout_q[i];
                if (raw_q[i] != dout_q[i]) begin
                    // The FILT_LEN-th disagreeing edge commits; the count can never pass it.
                    if (cnt_q[i] >= FILT_LAST) begin
                        dout_d[i] = raw_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + FCW'(1);
                    end
                end
                chg_d[i] = dout_d[i] ^ dout_q[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_OFF;
            pg_cnt_q <= '0;
            raw_q    <= '0;
            dout_q   <= '0;
            chg_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pg_cnt_q <= pg_cnt_d;
            raw_q    <= raw_d;
            dout_q   <= dout_d;
            chg_q    <= chg_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign DOUT  = dout_q;
    assign CHG   = chg_q;
    assign PGOOD = (state_q == ST_ON);

    // Output voltage follows the supply rails combinationally, not on a clock edge.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_vout
            assign VOUT[gi] = (state_q == ST_ON) ? (dout_q[gi] ? VCC_HIGH : VCC_LOW) : 0.0;
        end
    endgenerate

endmodule

// File: tb/tb_level_shifter_mc.sv
// Directed bench for level_shifter_mc: power-up, filtering, hysteresis,
// multi-channel, supply loss and asynchronous reset.
module tb_level_shifter_mc;

    logic       clk;
    logic       rst_n;
    logic       en;
    real        vin [4];
    real        vcc_low;
    real        vcc_high;
    real        vout [4];
    logic [3:0] dout;
    logic [3:0] chg;
    logic       pgood;

    int checks   = 0;
    int failures = 0;

    level_shifter_mc dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .EN       (en),
        .VIN      (vin),
        .VCC_LOW  (vcc_low),
        .VCC_HIGH (vcc_high),
        .VOUT     (vout),
        .DOUT     (dout),
        .CHG      (chg),
        .PGOOD    (pgood)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_real(input string tag, input real obs, input real exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
        end
        $display("check %s observed=%f expected=%f", tag, obs, exp);
    endtask

    task automatic set_all(input real v);
        for (int i = 0; i < 4; i++) vin[i] = v;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        vcc_low  = 1.2;
        vcc_high = 3.3;
        set_all(0.0);

        // Reset state
        #1;
        chk("rst_pgood", pgood, 0);
        chk("rst_dout", dout, 0);
        chk("rst_chg", chg, 0);
        chk_real("rst_vout0", vout[0], 0.0);
        step(2);
        rst_n = 1'b1;
        en    = 1'b1;

        // Power-up: leave OFF on edge 1, ON 8 edges later
        step(1);
        chk("pu_wait_pgood", pgood, 0);
        step(7);
        chk("pu_pre_pgood", pgood, 0);
        chk_real("pu_pre_vout0", vout[0], 0.0);
        step(1);
        chk("pu_pgood", pgood, 1);
        chk_real("pu_vout0_low", vout[0], 1.2);

        // Step on ch0: raw on edge 1, commit on the 3rd disagreeing edge
        vin[0] = 2.5;
        step(3);
        chk("flt_dout0_early", dout[0], 0);
        step(1);
        chk("flt_dout0_rise", dout[0], 1);
        chk("flt_chg0_rise", chg, 4'h1);
        chk_real("flt_vout0_high", vout[0], 3.3);
        step(1);
        chk("flt_chg0_clear", chg, 4'h0);
        chk("flt_dout0_hold", dout[0], 1);

        vin[0] = 0.0;
        step(4);
        chk("flt_dout0_fall", dout[0], 0);
        chk("flt_chg0_fall", chg, 4'h1);

        // Two-cycle glitch must be rejected
        vin[0] = 2.5;
        step(2);
        vin[0] = 0.0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("glitch_dout0", dout[0], 0);
            chk("glitch_chg", chg, 4'h0);
        end

        // Hysteresis on ch1
        vin[1] = 1.0;
        step(1);
        vin[1] = 1.8;
        step(6);
        chk("hys_1v8_up", dout[1], 0);
        vin[1] = 2.0;
        step(4);
        chk("hys_2v0", dout[1], 1);
        vin[1] = 1.8;
        step(6);
        chk("hys_1v8_down", dout[1], 1);
        vin[1] = 1.6;
        step(4);
        chk("hys_1v6", dout[1], 0);

        // All channels toggle together
        set_all(2.5);
        step(3);
        chk("mc_rise_early", dout, 4'h0);
        step(1);
        chk("mc_rise_dout", dout, 4'hF);
        chk("mc_rise_chg", chg, 4'hF);
        chk_real("mc_vout3_high", vout[3], 3.3);
        set_all(0.0);
        step(4);
        chk("mc_fall_dout", dout, 4'h0);
        chk("mc_fall_chg", chg, 4'hF);
        chk_real("mc_vout2_low", vout[2], 1.2);
        vcc_low = 1.5;
        #1;
        chk_real("mc_vcc_low_track", vout[1], 1.5);
        vcc_low = 1.2;

        // Supply loss while ch0 is high
        vin[0] = 2.5;
        step(4);
        chk("sl_dout0_pre", dout[0], 1);
        vcc_high = 2.5;
        #1;
        chk_real("sl_vout0_track", vout[0], 2.5);
        step(1);
        chk("sl_pgood", pgood, 0);
        chk("sl_dout", dout, 4'h0);
        chk_real("sl_vout0", vout[0], 0.0);
        vcc_high = 3.3;
        step(8);
        chk("sl_rewait_pgood", pgood, 0);
        step(1);
        chk("sl_restore_pgood", pgood, 1);
        chk("sl_restore_dout", dout, 4'h0);
        step(4);
        chk("sl_restore_dout0", dout[0], 1);

        // Asynchronous reset while ON: outputs drop between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_on_pgood", pgood, 0);
        chk("ar_on_dout", dout, 4'h0);
        chk_real("ar_on_vout0", vout[0], 0.0);
        step(1);
        rst_n = 1'b1;

        // Reset mid-WAIT discards the partial count
        step(4);
        chk("ar_wait_pgood", pgood, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_wait_pgood_rst", pgood, 0);
        step(1);
        rst_n = 1'b1;
        step(8);
        chk("ar_full_wait", pgood, 0);
        step(1);
        chk("ar_pgood", pgood, 1);

        // Dropping enable returns to OFF on the next edge
        en = 1'b0;
        step(1);
        chk("en_off_pgood", pgood, 0);
        chk_real("en_off_vout0", vout[0], 0.0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/level_shifter_mc.md
LEVEL_SHIFTER_MC -- requirements
Module: level_shifter_mc

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of independent channels (1..32).
REQ-002 The block SHALL have parameter VTH_HI, default 1.9 (real, V), giving the rising input threshold.
REQ-003 The block SHALL have parameter VTH_LO, default 1.7 (real, V), giving the falling input threshold; VTH_LO <= VTH_HI.
REQ-004 The block SHALL have parameter FILT_LEN, default 3 (int >= 1), giving the consecutive disagreeing samples needed to change a channel.
REQ-005 The block SHALL have parameter PG_MIN, default 3.0 (real, V), giving the minimum valid VCC_HIGH.
REQ-006 The block SHALL have parameter PG_DLY, default 8 (int >= 1), giving the supply settle time in cycles.
REQ-007 CLK  input  1  sole clock; all state updates occur on its rising edge.
REQ-008 RST_N  input  1  asynchronous, active-low reset.
REQ-009 EN  input  1  block enable, sampled on CLK.
REQ-010 VIN  input  real[N_CH]  per-channel analog input, wreal1driver.
REQ-011 VCC_LOW  input  real  low-side supply, wreal1driver.
REQ-012 VCC_HIGH  input  real  high-side supply, wreal1driver.
REQ-013 VOUT  output  real[N_CH]  per-channel shifted output voltage.
REQ-014 DOUT  output  N_CH  filtered logic level per channel.
REQ-015 CHG  output  N_CH  one-cycle pulse when the corresponding DOUT changes.
REQ-016 PGOOD  output  1  high when the supply FSM is in ON.

Function
REQ-017 The supply FSM SHALL have states OFF, WAIT and ON, with a PG_DLY-cycle counter.
REQ-018 OFF->WAIT SHALL occur on the edge where EN=1 and VCC_HIGH >= PG_MIN; the counter SHALL load 0.
REQ-019 In WAIT, the counter SHALL increment each cycle and WAIT->ON SHALL occur on the edge where the counter equals PG_DLY-1; PGOOD rises PG_DLY cycles after leaving OFF.
REQ-020 From WAIT or ON, any edge sampling EN=0 or VCC_HIGH < PG_MIN SHALL return to OFF, with priority over all other transitions.
REQ-021 The raw level per channel SHALL be 1 if VIN > VTH_HI, 0 if VIN < VTH_LO, else the previous raw level (hysteresis), registered on CLK.
REQ-022 Each channel SHALL own a counter of width clog2(FILT_LEN+1) that clears whenever raw == DOUT.
REQ-023 While raw != DOUT, the counter SHALL increment; on the FILT_LEN-th consecutive disagreeing edge, DOUT SHALL take raw and the counter SHALL clear.
REQ-024 The counter SHALL saturate and never wrap.
REQ-025 With FILT_LEN=1, DOUT SHALL follow raw with one cycle of latency.
REQ-026 CHG[i] SHALL be high for exactly the one cycle following an edge where DOUT[i] changed.
REQ-027 Outside ON, every channel's raw level, counter, DOUT and CHG SHALL be held at 0.
REQ-028 Filtering SHALL start on the first edge in ON.
REQ-029 In ON, VOUT[i] SHALL be VCC_HIGH when DOUT[i]=1 and VCC_LOW otherwise, tracking supply values continuously without a clock edge.
REQ-030 Outside ON, VOUT[i] SHALL be 0.0.
REQ-031 Channels SHALL be fully independent.
REQ-032 Simultaneous transitions on several channels SHALL each be handled in the same cycle.

Reset
REQ-033 While RST_N=0, the block SHALL immediately force the FSM to OFF, all counters to 0, DOUT=0, CHG=0, PGOOD=0 and VOUT=0.0, regardless of CLK.
REQ-034 After RST_N rises, the first state change SHALL occur on the first CLK edge.
REQ-035 Reset asserted mid-WAIT or mid-filter SHALL discard all partial counts.

Verification
REQ-036 Power-up: EN=1, VCC_HIGH=3.3 after reset -> PGOOD=1 exactly 8 cycles later; VOUT=0.0 before that.
REQ-037 Filtering: in ON, VIN[0] steps 0->2.5 V -> DOUT[0]=1 on the 3rd edge, CHG[0] pulses one cycle, and VOUT[0]=3.3; a 2-cycle glitch to 2.5 V -> no change.
REQ-038 Hysteresis: VIN ramps 0->1.8 V -> DOUT stays 0; then 2.0 V -> DOUT becomes 1; then back to 1.8 V -> DOUT stays 1; then 1.6 V -> DOUT becomes 0.
REQ-039 Supply loss: in ON with DOUT=1, VCC_HIGH drops to 2.5 V -> next edge OFF, PGOOD=0, DOUT=0, VOUT=0.0; restoring to 3.3 V -> PGOOD again after 8 cycles.
REQ-040 Async reset mid-WAIT (cycle 4): RST_N low between edges -> outputs zero immediately; re-enable -> full 8-cycle wait.
REQ-041 Multi-channel: N_CH=4, all VIN toggle at once -> all DOUT and CHG update on the same edge; VCC_LOW=1.2 is reflected on the low channels.
